// File: rtl/data_memory.sv
// Word-organised data RAM for the CPU MEM stage: byte-addressed, per-lane write
// enables, combinational chip-enable-qualified read and synchronous write.

module data_memory_chk (
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  logic ce
);

    // Control inputs must be resolved whenever the memory is out of reset
    a_ctrl_known: assert property (@(posedge clk) disable iff (rst) !$isunknown({we, ce}));

endmodule

module data_memory #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  we,
    input  logic [3:0]            byte_slct,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("data_memory: DATA_WIDTH must be 32");
        end
        if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
            $error("data_memory: DEPTH_WORDS must be a power of two");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_data [0:DEPTH_WORDS-1];

    logic [IDX_W-1:0]      w_index;
    logic                  w_unused;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Sub-word position travels in byte_slct, so the low two address bits are dropped
    assign w_index  = addr_i[IDX_W+1:2];
    assign w_unused = ^{addr_i[1:0], addr_i[ADDR_WIDTH-1:IDX_W+2]};
    assign w_rd_word = mem_data[w_index];

    function automatic logic [DATA_WIDTH-1:0] f_lane_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            lanes
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (lanes[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                merged[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

    // Lane-masked synchronous write; an edge seen while rst is high writes nothing
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem_data[w_index] <= f_lane_merge(w_rd_word, data_i, byte_slct);
        end
    end

    // Combinational read, forced to zero by reset or a deasserted chip enable
    always_comb begin
        data_o = {DATA_WIDTH{1'b0}};
        if (rst) begin
            data_o = {DATA_WIDTH{1'b0}};
        end else if (!ce) begin
            data_o = {DATA_WIDTH{1'b0}};
        end else begin
            data_o = w_rd_word;
        end
    end

    data_memory_chk u_chk (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .ce  (ce)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed vector bench for data_memory: a table of per-cycle stimulus with the
// expected pre-edge read value, plus hand sequences for reset and same-cycle read-after-write.

module tb_data_memory;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        we;
    logic [3:0]  byte_slct;
    logic [31:0] data_o;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic        ce;
        logic        we;
        logic [3:0]  bsel;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    data_memory #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .we        (we),
        .byte_slct (byte_slct),
        .data_o    (data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        ce        = 1'b0;
        we        = 1'b0;
        byte_slct = 4'b0000;
        addr_i    = 32'h0000_0000;
        data_i    = 32'h0000_0000;
        checks    = 0;
        errors    = 0;

        dut.mem_data[0]  = 32'h0000_0000;
        dut.mem_data[4]  = 32'h1122_3344;
        dut.mem_data[12] = 32'h5566_7788;
        dut.mem_data[16] = 32'h0102_0304;

        //           rst   ce    we    bsel     addr          din           exp (before edge)
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0010, 32'h0000_0000, 32'h1122_3344};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0020, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'b0100, 32'h0000_0020, 32'h00AA_0000, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'h0000_1234, 32'hDEAA_BEEF};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0020, 32'h0000_0000, 32'hDEAA_1234};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 32'h0000_0020, 32'hFFFF_FFFF, 32'hDEAA_1234};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0022, 32'h0000_0000, 32'hDEAA_1234};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 4'b1111, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0003, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0001_2002, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'b1000, 32'h0000_0040, 32'h7F00_0000, 32'h0000_0000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0040, 32'h0000_0000, 32'h7F02_0304};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_0030, 32'h0000_0000, 32'h5566_7788};

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            ce        = vecs[i].ce;
            we        = vecs[i].we;
            byte_slct = vecs[i].bsel;
            addr_i    = vecs[i].addr;
            data_i    = vecs[i].din;
            #1;
            check($sformatf("vec%0d", i), data_o, vecs[i].exp);
        end

        // Reset raised between edges with a full-word write pending to word 12
        @(negedge clk);
        rst       = 1'b0;
        ce        = 1'b1;
        we        = 1'b1;
        byte_slct = 4'b1111;
        addr_i    = 32'h0000_0030;
        data_i    = 32'h0BAD_F00D;
        #1;
        check("rst_pre", data_o, 32'h5566_7788);
        #1;
        rst = 1'b1;
        #1;
        check("rst_immediate", data_o, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("rst_after_edge", data_o, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        #1;
        check("rst_retained", data_o, 32'h5566_7788);

        // Same-word read-during-write: old word before the edge, merged word right after
        @(negedge clk);
        we        = 1'b1;
        byte_slct = 4'b1111;
        addr_i    = 32'h0000_0020;
        data_i    = 32'h0123_4567;
        #1;
        check("rdw_before", data_o, 32'hDEAA_1234);
        @(posedge clk);
        #1;
        check("rdw_after", data_o, 32'h0123_4567);
        @(negedge clk);
        byte_slct = 4'b1001;
        data_i    = 32'hAA00_00BB;
        #1;
        check("rdw2_before", data_o, 32'h0123_4567);
        @(posedge clk);
        #1;
        check("rdw2_after", data_o, 32'hAA23_45BB);
        @(negedge clk);
        we = 1'b0;
        ce = 1'b0;
        #1;
        check("ce_low_final", data_o, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
